// File: rtl/freq_gen_ctrl.sv
// Command sequencer for the square-wave generator: turns a divider + duty-percent
// request (single point or stepped sweep) into freq/duty update pulse pairs.
module freq_gen_ctrl #(
    parameter logic [31:0] INIT_DIVIDER   = 32'd1350,
    parameter logic [31:0] INIT_DUTY_HIGH = 32'd1350
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_mode,
    input  logic [31:0] cfg_div_start,
    input  logic [31:0] cfg_div_stop,
    input  logic [31:0] cfg_div_step,
    input  logic [6:0]  cfg_duty_pct,
    input  logic [31:0] cfg_dwell,
    input  logic        abort,
    output logic [31:0] freq_divider,
    output logic        freq_update,
    output logic [31:0] duty_cycle_high,
    output logic        duty_update,
    output logic        busy,
    output logic        seq_done,
    output logic        cfg_err
);

    typedef enum logic [2:0] {IDLE, CALC, APPLY_F, APPLY_D, DWELL, DONE} state_t;

    state_t      state, state_nxt;
    logic        mode_r, dir_up, abort_pend, err_r;
    logic [31:0] cur, stop_r, step_r, dwell_r, dcnt;
    logic [6:0]  pct_r, rem;
    logic [5:0]  cnt;
    logic [39:0] quo;

    logic        accept, cfg_bad, at_stop, ge;
    logic [32:0] sum_up, diff_dn;
    logic [31:0] next_div;
    logic [7:0]  rem_sh;

    function automatic logic [39:0] duty_product(input logic [31:0] d, input logic [6:0] p);
        return ({8'd0, d} * {33'd0, p}) << 1;
    endfunction

    assign accept  = cfg_valid && (state == IDLE);
    assign cfg_bad = (cfg_div_start == 32'd0) || (cfg_duty_pct == 7'd0) || (cfg_duty_pct > 7'd99) ||
                     (cfg_mode && ((cfg_div_stop == 32'd0) || (cfg_div_step == 32'd0)));
    assign at_stop = (cur == stop_r);

    // 33-bit step arithmetic so neither direction can wrap past the stop point
    always_comb begin
        sum_up  = {1'b0, cur} + {1'b0, step_r};
        diff_dn = {1'b0, cur} - {1'b0, step_r};
        if (dir_up)
            next_div = (sum_up >= {1'b0, stop_r}) ? stop_r : sum_up[31:0];
        else
            next_div = (diff_dn[32] || (diff_dn[31:0] <= stop_r)) ? stop_r : diff_dn[31:0];
    end

    // one quotient bit per cycle: 40-bit dividend over the constant 100
    assign rem_sh = {rem, quo[39]};
    assign ge     = (rem_sh >= 8'd100);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !cfg_bad) state_nxt = CALC;
            CALC:    if (abort) state_nxt = IDLE;
                     else if (cnt == 6'd39) state_nxt = APPLY_F;
            APPLY_F: state_nxt = APPLY_D;
            APPLY_D: if (abort_pend || abort) state_nxt = IDLE;
                     else if (mode_r) state_nxt = DWELL;
                     else state_nxt = DONE;
            DWELL:   if (abort) state_nxt = IDLE;
                     else if (dcnt == 32'd0) state_nxt = at_stop ? DONE : CALC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready   = (state == IDLE);
        busy        = (state != IDLE);
        freq_update = (state == APPLY_F);
        duty_update = (state == APPLY_D);
        seq_done    = (state == DONE) && !abort;
        cfg_err     = err_r;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_r          <= 1'b0;
            dir_up          <= 1'b0;
            abort_pend      <= 1'b0;
            err_r           <= 1'b0;
            cur             <= '0;
            stop_r          <= '0;
            step_r          <= '0;
            dwell_r         <= '0;
            dcnt            <= '0;
            pct_r           <= '0;
            rem             <= '0;
            cnt             <= '0;
            quo             <= '0;
            freq_divider    <= INIT_DIVIDER;
            duty_cycle_high <= INIT_DUTY_HIGH;
        end else begin
            err_r      <= accept && cfg_bad;
            abort_pend <= (state == APPLY_F) && abort;
            case (state)
                IDLE: if (accept && !cfg_bad) begin
                    mode_r  <= cfg_mode;
                    dir_up  <= (cfg_div_stop >= cfg_div_start);
                    cur     <= cfg_div_start;
                    stop_r  <= cfg_div_stop;
                    step_r  <= cfg_div_step;
                    pct_r   <= cfg_duty_pct;
                    dwell_r <= cfg_dwell;
                    cnt     <= '0;
                    rem     <= '0;
                    quo     <= duty_product(cfg_div_start, cfg_duty_pct);
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    quo <= {quo[38:0], ge};
                    rem <= 7'(ge ? rem_sh - 8'd100 : rem_sh);
                    if (state_nxt == APPLY_F) freq_divider <= cur;
                end
                APPLY_F: begin
                    // saturate rather than truncate; a zero duty would stall the generator
                    if (quo[39:32] != 8'd0)   duty_cycle_high <= '1;
                    else if (quo[31:0] == 0)  duty_cycle_high <= 32'd1;
                    else                      duty_cycle_high <= quo[31:0];
                end
                APPLY_D: dcnt <= (dwell_r == 32'd0) ? 32'd0 : dwell_r - 32'd1;
                DWELL: begin
                    if (dcnt != 32'd0) begin
                        dcnt <= dcnt - 32'd1;
                    end else if (!at_stop) begin
                        cur <= next_div;
                        cnt <= '0;
                        rem <= '0;
                        quo <= duty_product(next_div, pct_r);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gen_ctrl.sv
// Randomized + directed bench for freq_gen_ctrl against a point-list/timing model.
module tb_freq_gen_ctrl;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        cfg_valid = 1'b0, cfg_mode = 1'b0, abort = 1'b0;
    logic [31:0] cfg_div_start = '0, cfg_div_stop = '0, cfg_div_step = '0, cfg_dwell = '0;
    logic [6:0]  cfg_duty_pct = '0;
    logic        cfg_ready, freq_update, duty_update, busy, seq_done, cfg_err;
    logic [31:0] freq_divider, duty_cycle_high;

    int errors = 0, checks = 0, cyc = 0, busy_cnt = 0, overlap = 0;
    int          fq_cyc[$], dq_cyc[$], sq_cyc[$], eq_cyc[$];
    logic [31:0] fq_val[$], dq_val[$];
    longint      exp_div[$], exp_duty[$];

    freq_gen_ctrl dut (
        .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_div_start(cfg_div_start), .cfg_div_stop(cfg_div_stop),
        .cfg_div_step(cfg_div_step), .cfg_duty_pct(cfg_duty_pct), .cfg_dwell(cfg_dwell),
        .abort(abort), .freq_divider(freq_divider), .freq_update(freq_update),
        .duty_cycle_high(duty_cycle_high), .duty_update(duty_update), .busy(busy),
        .seq_done(seq_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (freq_update) begin fq_cyc.push_back(cyc); fq_val.push_back(freq_divider); end
        if (duty_update) begin dq_cyc.push_back(cyc); dq_val.push_back(duty_cycle_high); end
        if (seq_done) sq_cyc.push_back(cyc);
        if (cfg_err)  eq_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (freq_update && duty_update) overlap++;
    end

    task automatic clear_mon();
        fq_cyc.delete(); fq_val.delete(); dq_cyc.delete(); dq_val.delete();
        sq_cyc.delete(); eq_cyc.delete(); busy_cnt = 0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // drives one command for a single cycle; acc = edge count of the accept edge
    task automatic send(input bit m, input logic [31:0] s, e, st, input logic [6:0] p,
                        input logic [31:0] dw, output int acc);
        @(negedge clk);
        cfg_mode = m; cfg_div_start = s; cfg_div_stop = e; cfg_div_step = st;
        cfg_duty_pct = p; cfg_dwell = dw; cfg_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        cfg_valid = 1'b0;
    endtask

    // expected divider/duty list from the sweep rules in plain arithmetic
    task automatic build_model(input bit m, input longint s, e, st, p);
        longint d, q;
        exp_div.delete(); exp_duty.delete();
        d = s;
        for (int k = 0; k < 1000; k++) begin
            exp_div.push_back(d);
            q = (2 * d * p) / 100;
            exp_duty.push_back(q == 0 ? 1 : q);
            if (!m || d == e) break;
            if (e >= s) d = (d + st > e) ? e : d + st;
            else        d = (d - st < e) ? e : d - st;
        end
    endtask

    task automatic run_seq(input string nm, input bit m, input logic [31:0] s, e, st,
                           input logic [6:0] p, input logic [31:0] dw);
        int acc, n, lim, de, k, f, done;
        build_model(m, s, e, st, p);
        de = (dw == 0) ? 1 : int'(dw);
        clear_mon();
        send(m, s, e, st, p, dw, acc);
        n = exp_div.size();
        lim = n * (45 + de) + 50;
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < lim);
        checks++;
        if (busy) begin errors++; $display("FAIL %s timeout: busy still 1 after %0d cycles", nm, k); end
        repeat (2) @(negedge clk);
        checks++;
        if (fq_cyc.size() !== n || dq_cyc.size() !== n || sq_cyc.size() !== 1) begin
            errors++;
            $display("FAIL %s counts: freq=%0d duty=%0d done=%0d, expected %0d/%0d/1",
                     nm, fq_cyc.size(), dq_cyc.size(), sq_cyc.size(), n, n);
        end
        for (int i = 0; i < n && i < fq_cyc.size() && i < dq_cyc.size(); i++) begin
            f = acc + 40 + i * (42 + de);
            checks++;
            if (fq_cyc[i] !== f || fq_val[i] !== 32'(exp_div[i])) begin
                errors++;
                $display("FAIL %s freq[%0d]: cyc=%0d div=%0d, expected cyc=%0d div=%0d",
                         nm, i, fq_cyc[i] - acc, fq_val[i], f - acc, exp_div[i]);
            end
            checks++;
            if (dq_cyc[i] !== f + 1 || dq_val[i] !== 32'(exp_duty[i])) begin
                errors++;
                $display("FAIL %s duty[%0d]: cyc=%0d duty=%0d, expected cyc=%0d duty=%0d",
                         nm, i, dq_cyc[i] - acc, dq_val[i], f + 1 - acc, exp_duty[i]);
            end
        end
        done = acc + 40 + (n - 1) * (42 + de) + 2 + (m ? de : 0);
        if (sq_cyc.size() > 0) begin
            checks++;
            if (sq_cyc[0] !== done) begin
                errors++;
                $display("FAIL %s seq_done: cyc=%0d, expected %0d", nm, sq_cyc[0] - acc, done - acc);
            end
        end
        checks++;
        if (busy_cnt !== done - acc + 1) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", nm, busy_cnt, done - acc + 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (freq_divider !== 32'd1350 || duty_cycle_high !== 32'd1350 || cfg_ready !== 1'b1 ||
            busy !== 1'b0 || freq_update !== 1'b0 || duty_update !== 1'b0 ||
            seq_done !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: div=%0d duty=%0d rdy=%b busy=%b fu=%b du=%b done=%b err=%b, expected 1350 1350 1 0 0 0 0 0",
                     freq_divider, duty_cycle_high, cfg_ready, busy, freq_update, duty_update, seq_done, cfg_err);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || freq_divider !== 32'd1350) begin
            errors++;
            $display("FAIL after_reset: rdy=%b busy=%b div=%0d, expected 1 0 1350", cfg_ready, busy, freq_divider);
        end
    endtask

    task automatic test_reject();
        int acc;
        logic [31:0] s[4]  = '{32'd500, 32'd500, 32'd100, 32'd0};
        logic [6:0]  p[4]  = '{7'd0, 7'd100, 7'd50, 7'd50};
        logic [31:0] st[4] = '{32'd10, 32'd10, 32'd0, 32'd10};
        bit          m[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            send(m[i], s[i], 32'd200, st[i], p[i], 32'd3, acc);
            repeat (5) @(negedge clk);
            checks++;
            if (eq_cyc.size() !== 1 || (eq_cyc.size() == 1 && eq_cyc[0] !== acc)) begin
                errors++;
                $display("FAIL reject%0d cfg_err: pulses=%0d, expected 1 in cycle 1", i, eq_cyc.size());
            end
            checks++;
            if (fq_cyc.size() !== 0 || dq_cyc.size() !== 0 || busy_cnt !== 0) begin
                errors++;
                $display("FAIL reject%0d side effects: freq=%0d duty=%0d busy=%0d, expected 0 0 0",
                         i, fq_cyc.size(), dq_cyc.size(), busy_cnt);
            end
        end
    endtask

    task automatic test_abort();
        int acc;
        // abort during DWELL
        clear_mon();
        send(1'b1, 32'd100, 32'd130, 32'd15, 7'd50, 32'd10, acc);
        wait_cyc(acc + 45);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL abort_dwell idle: busy=%b rdy=%b, expected 0 1", busy, cfg_ready);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (fq_cyc.size() !== 1 || dq_cyc.size() !== 1 || sq_cyc.size() !== 0) begin
            errors++;
            $display("FAIL abort_dwell pulses: freq=%0d duty=%0d done=%0d, expected 1 1 0",
                     fq_cyc.size(), dq_cyc.size(), sq_cyc.size());
        end
        // abort during CALC
        clear_mon();
        send(1'b1, 32'd100, 32'd130, 32'd15, 7'd50, 32'd10, acc);
        wait_cyc(acc + 10);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (fq_cyc.size() !== 0 || dq_cyc.size() !== 0 || sq_cyc.size() !== 0 || busy_cnt !== 11) begin
            errors++;
            $display("FAIL abort_calc: freq=%0d duty=%0d done=%0d busy=%0d, expected 0 0 0 11",
                     fq_cyc.size(), dq_cyc.size(), sq_cyc.size(), busy_cnt);
        end
        // abort in APPLY_F: the duty half of the pair still goes out
        clear_mon();
        send(1'b0, 32'd1350, 32'd0, 32'd0, 7'd25, 32'd0, acc);
        wait_cyc(acc + 40);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (duty_update !== 1'b1 || duty_cycle_high !== 32'd675) begin
            errors++;
            $display("FAIL abort_applyf duty: du=%b duty=%0d, expected 1 675", duty_update, duty_cycle_high);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_applyf idle: busy=%b rdy=%b done=%b, expected 0 1 0", busy, cfg_ready, seq_done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (sq_cyc.size() !== 0 || fq_cyc.size() !== 1) begin
            errors++;
            $display("FAIL abort_applyf pulses: done=%0d freq=%0d, expected 0 1", sq_cyc.size(), fq_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        send(1'b1, 32'd200, 32'd400, 32'd100, 7'd50, 32'd20, acc);
        wait_cyc(acc + 45);
        checks++;
        if (freq_divider !== 32'd200 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_seq: div=%0d busy=%b, expected 200 1", freq_divider, busy);
        end
        resetn = 1'b0; #1;
        checks++;
        if (freq_divider !== 32'd1350 || duty_cycle_high !== 32'd1350 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: div=%0d duty=%0d busy=%b rdy=%b, expected 1350 1350 0 1",
                     freq_divider, duty_cycle_high, busy, cfg_ready);
        end
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] s, e, st, rng;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                s = $urandom_range(32'h7FFF_FFFF, 1);
                run_seq("rand_single", 1'b0, s, 32'd0, 32'd0, 7'($urandom_range(99, 1)), 32'd0);
            end else begin
                s = $urandom_range(3000, 1);
                e = $urandom_range(3000, 1);
                rng = (e >= s) ? e - s : s - e;
                st = $urandom_range(rng + 100, rng / 4 + 1);
                run_seq("rand_sweep", 1'b1, s, e, st, 7'($urandom_range(99, 1)), $urandom_range(6, 0));
            end
        end
        checks++;
        if (overlap !== 0) begin
            errors++; $display("FAIL pulse_overlap: %0d cycles with both updates, expected 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        run_seq("single", 1'b0, 32'd1350, 32'd0, 32'd0, 7'd25, 32'd0);
        run_seq("sweep_up", 1'b1, 32'd100, 32'd130, 32'd15, 7'd50, 32'd10);
        run_seq("sweep_down", 1'b1, 32'd100, 32'd10, 32'd40, 7'd10, 32'd0);
        run_seq("tiny_duty", 1'b0, 32'd3, 32'd0, 32'd0, 7'd1, 32'd0);
        test_reject();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/freq_gen_ctrl.md
Name: freq_gen_ctrl

Overview:
Sequencer that configures the adjustable square-wave generator from a host command. It converts a divider plus duty-percent request into the generator's `freq_divider`/`freq_update`/`duty_cycle_high`/`duty_update` pulse pair. It runs either a single setting or a stepped frequency sweep with a programmable dwell per point. It sits between the host command decoder and the generator, and is the only driver of the generator's config inputs.

Parameters:
INIT_DIVIDER, 1350, divider shown on `freq_divider` after reset (10 kHz at 27 MHz).
INIT_DUTY_HIGH, 1350, value on `duty_cycle_high` after reset (50%).

Ports:
clk  in  1  system clock, 27 MHz
resetn  in  1  asynchronous active-low reset
cfg_valid  in  1  command valid
cfg_ready  out  1  controller can accept a command
cfg_mode  in  1  0 = single setting, 1 = sweep
cfg_div_start  in  32  divider (single), or first sweep point
cfg_div_stop  in  32  last sweep point (ignored in single mode)
cfg_div_step  in  32  sweep step magnitude (ignored in single mode)
cfg_duty_pct  in  7  duty in percent, valid 1..99
cfg_dwell  in  32  clk cycles held per sweep point
abort  in  1  level; stop sequence
freq_divider  out  32  to generator
freq_update  out  1  1-cycle pulse to generator
duty_cycle_high  out  32  to generator
duty_update  out  1  1-cycle pulse to generator
busy  out  1  high in any state except IDLE
seq_done  out  1  1-cycle pulse when a sequence completes
cfg_err  out  1  1-cycle pulse when a command is rejected

Behaviour:
- Reset values:
  - `freq_divider` = INIT_DIVIDER, `duty_cycle_high` = INIT_DUTY_HIGH.
  - `freq_update`, `duty_update`, `busy`, `seq_done`, `cfg_err` = 0.
  - `cfg_ready` = 1. State = IDLE.
- Handshake:
  - A command is accepted on a clk edge where `cfg_valid & cfg_ready`. All cfg_* are captured on that edge.
  - `cfg_ready` = 1 only in IDLE.
- Validation at accept. The command is rejected if any of these hold:
  - `cfg_div_start` == 0
  - `cfg_duty_pct` == 0 or > 99
  - sweep mode and (`cfg_div_stop` == 0 or `cfg_div_step` == 0)
- On rejection: `cfg_err` pulses the next cycle, state stays IDLE, and no update pulses are issued.
- States: IDLE, CALC, APPLY_F, APPLY_D, DWELL, DONE.
- CALC:
  - Computes duty = floor(2·div·pct / 100) with a 40-bit product and a sequential restoring divider.
  - Takes exactly 40 cycles. A result of 0 is forced to 1.
  - Sweep direction is latched at accept: up if stop ≥ start, otherwise down.
- APPLY_F (1 cycle): `freq_divider` = current div, `freq_update` = 1.
- APPLY_D (1 cycle): `duty_cycle_high` = computed duty, `duty_update` = 1.
  - `freq_update` and `duty_update` are never high in the same cycle.
  - Data outputs are held stable between pulses.
- Latency: `freq_update` is high in the 41st cycle after the accept edge. `duty_update` is high in the 42nd cycle.
- Single mode: APPLY_D → DONE.
- Sweep mode: APPLY_D → DWELL.
  - DWELL lasts max(`cfg_dwell`, 1) cycles.
  - Then, if current == stop → DONE.
  - Otherwise next = current ± step, computed in 33 bits and clamped to stop (no overshoot, no wrap) → CALC.
- DONE (1 cycle): `seq_done` = 1 → IDLE.
- Abort:
  - Sampled in CALC, DWELL and DONE: go to IDLE next cycle, no further pulses, no `seq_done`.
  - In APPLY_F, abort is deferred: APPLY_D still executes, then IDLE. The freq/duty pair is atomic.
  - `cfg_valid` during abort is ignored until `cfg_ready` is high.
- Reset mid-sequence returns immediately to reset values. The generator keeps its last applied config.

Test Plan:
1. Reset → `freq_divider` = 1350, `duty_cycle_high` = 1350, `cfg_ready` = 1, all pulses 0.
2. Single: div = 1350, pct = 25 →
   - `freq_update` with `freq_divider` = 1350 at cycle 41 after accept
   - `duty_update` with `duty_cycle_high` = 675 at cycle 42
   - `seq_done` at cycle 43; `busy` high throughout.
3. Sweep up: start = 100, stop = 130, step = 15, pct = 50, dwell = 10 →
   - points 100, 115, 130 with duty 100, 115, 130
   - successive `freq_update` pulses 10 + 40 + 2 cycles apart
   - one `seq_done` after the final dwell.
4. Sweep down with clamp: start = 100, stop = 10, step = 40, pct = 10, dwell = 0 →
   - dividers 100, 60, 20, 10; duties 20, 12, 4, 2
   - dwell of 1 cycle each.
5. Rejects: pct = 0; pct = 100; sweep with step = 0; start = 0 →
   - each gives a single `cfg_err` pulse, no update pulses, `busy` stays 0.
6. Abort:
   - asserted during DWELL → IDLE next cycle, no further pulses, no `seq_done`.
   - asserted in the APPLY_F cycle → `duty_update` still issued the next cycle, then IDLE with `cfg_ready` = 1.
